// File: rtl/des_decrypt_key_schedule_pkg.sv
// ---------------------------------------------------------------------------
// des_pkg
// Shared definitions for the DES key schedule blocks.
//   PC1_IDX    : 56 source positions of Permuted Choice 1 (zero-based,
//                vector bit i holds DES bit i+1)
//   PC2_IDX    : 48 source positions of Permuted Choice 2 into {D,C}
//   DEC_SHIFT  : right-rotate amount applied when entering round r
//   ENC_SHIFT  : left-rotate amount; entry 0 is applied at key load
//   state_t    : scheduler FSM states
//   rot28      : 28-bit rotate helper in codebase bit order
// ---------------------------------------------------------------------------
package des_pkg;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [5:0] PC1_IDX [0:55] = '{
        56, 48, 40, 32, 24, 16,  8,
         0, 57, 49, 41, 33, 25, 17,
         9,  1, 58, 50, 42, 34, 26,
        18, 10,  2, 59, 51, 43, 35,
        62, 54, 46, 38, 30, 22, 14,
         6, 61, 53, 45, 37, 29, 21,
        13,  5, 60, 52, 44, 36, 28,
        20, 12,  4, 27, 19, 11,  3
    };

    localparam logic [5:0] PC2_IDX [0:47] = '{
        13, 16, 10, 23,  0,  4,
         2, 27, 14,  5, 20,  9,
        22, 18, 11,  3, 25,  7,
        15,  6, 26, 19, 12,  1,
        40, 51, 30, 36, 46, 54,
        29, 39, 50, 44, 32, 47,
        43, 48, 38, 55, 33, 52,
        45, 41, 49, 35, 28, 31
    };

    // Round 0 of decryption needs no shift: C0/D0 already equals C16/D16.
    localparam logic [1:0] DEC_SHIFT [0:15] = '{
        0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    localparam logic [1:0] ENC_SHIFT [0:15] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    // DES "left" moves bits toward DES bit 1, which is vector bit 0, so a
    // DES left rotate is a vector right rotate and vice versa.
    function automatic logic [27:0] rot28(input logic [27:0] v,
                                          input logic [1:0]  amt,
                                          input logic        left);
        logic [27:0] r;
        r = v;
        if (left) begin
            if (amt == 2'd1)      r = {v[0], v[27:1]};
            else if (amt == 2'd2) r = {v[1:0], v[27:2]};
        end else begin
            if (amt == 2'd1)      r = {v[26:0], v[27]};
            else if (amt == 2'd2) r = {v[25:0], v[27:26]};
        end
        return r;
    endfunction

endpackage

// File: rtl/des_decrypt_key_schedule_if.sv
// ---------------------------------------------------------------------------
// des_decrypt_key_schedule_if
// Key-load and subkey-stream handshakes of the key scheduler.
//   key_in/key_valid/key_ready       : 64-bit key input handshake
//   subkey/subkey_round/subkey_valid : round subkey stream
//   subkey_ready                     : consumer accepts the subkey
//   done                             : pulse on the round-15 transfer
// slave = the scheduler, master = key source and round datapath.
// ---------------------------------------------------------------------------
interface des_decrypt_key_schedule_if;
    logic [63:0] key_in;
    logic        key_valid;
    logic        key_ready;
    logic [47:0] subkey;
    logic [3:0]  subkey_round;
    logic        subkey_valid;
    logic        subkey_ready;
    logic        done;

    modport master (
        output key_in, key_valid, subkey_ready,
        input  key_ready, subkey, subkey_round, subkey_valid, done
    );

    modport slave (
        input  key_in, key_valid, subkey_ready,
        output key_ready, subkey, subkey_round, subkey_valid, done
    );
endinterface

// File: rtl/des_decrypt_key_schedule_pc1.sv
// ---------------------------------------------------------------------------
// Permuted_Choice_1
// Combinational DES PC1: 64-bit key to 56-bit {D,C}.
//   key_in  : 64-bit key, key_in[0] = DES bit 1
//   pc1_out : [27:0] = C, [55:28] = D
// ---------------------------------------------------------------------------
module Permuted_Choice_1
    import des_pkg::*;
(
    input  logic [63:0] key_in,
    output logic [55:0] pc1_out
);

    for (genvar j = 0; j < 56; j++) begin : g_bit
        assign pc1_out[j] = key_in[PC1_IDX[j]];
    end

    // Parity bits (every eighth DES bit) never reach the schedule.
    logic unused_parity;
    assign unused_parity = ^{key_in[7], key_in[15], key_in[23], key_in[31],
                             key_in[39], key_in[47], key_in[55], key_in[63]};

endmodule

// File: rtl/des_decrypt_key_schedule_pc2.sv
// ---------------------------------------------------------------------------
// Permuted_Choice_2
// Combinational DES PC2: 56-bit {D,C} compressed to a 48-bit subkey.
//   cd_in  : {D,C}, cd_in[0] = DES bit 1 of C
//   subkey : subkey[0] = DES subkey bit 1
// ---------------------------------------------------------------------------
module Permuted_Choice_2
    import des_pkg::*;
(
    input  logic [55:0] cd_in,
    output logic [47:0] subkey
);

    for (genvar j = 0; j < 48; j++) begin : g_bit
        assign subkey[j] = cd_in[PC2_IDX[j]];
    end

    // Eight C/D positions are dropped by the compression.
    logic unused_cd;
    assign unused_cd = ^{cd_in[8], cd_in[17], cd_in[21], cd_in[24],
                         cd_in[34], cd_in[37], cd_in[42], cd_in[53]};

endmodule

// File: rtl/des_decrypt_key_schedule.sv
// ---------------------------------------------------------------------------
// des_decrypt_key_schedule
// Sequential DES key scheduler streaming the sixteen round subkeys, K16
// first by default (ENCRYPT_ORDER=1 gives K1 first).
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : slave side of des_decrypt_key_schedule_if (key load handshake,
//         subkey stream handshake, done pulse)
// ---------------------------------------------------------------------------
module des_decrypt_key_schedule
    import des_pkg::*;
#(
    parameter bit ENCRYPT_ORDER = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst,
    des_decrypt_key_schedule_if.slave     bus
);

    state_t      state;
    logic [27:0] c_reg;
    logic [27:0] d_reg;
    logic [3:0]  round;
    logic        key_ready_q;
    logic        subkey_valid_q;

    logic [55:0] pc1_out;
    logic [27:0] c_load;
    logic [27:0] d_load;
    logic [3:0]  next_round;
    logic [1:0]  shift_amt;
    logic [27:0] c_next;
    logic [27:0] d_next;
    logic [47:0] subkey_w;

    Permuted_Choice_1 u_pc1 (
        .key_in  (bus.key_in),
        .pc1_out (pc1_out)
    );

    // Encrypt order starts at K1, whose one-place shift is folded into the load.
    assign c_load = rot28(pc1_out[27:0],  ENCRYPT_ORDER ? 2'd1 : 2'd0, ENCRYPT_ORDER);
    assign d_load = rot28(pc1_out[55:28], ENCRYPT_ORDER ? 2'd1 : 2'd0, ENCRYPT_ORDER);

    assign next_round = round + 4'd1;
    assign shift_amt  = ENCRYPT_ORDER ? ENC_SHIFT[next_round] : DEC_SHIFT[next_round];
    assign c_next     = rot28(c_reg, shift_amt, ENCRYPT_ORDER);
    assign d_next     = rot28(d_reg, shift_amt, ENCRYPT_ORDER);

    Permuted_Choice_2 u_pc2 (
        .cd_in  ({d_reg, c_reg}),
        .subkey (subkey_w)
    );

    // FSM: load C/D on an accepted key, then advance one round per accepted
    // subkey; the round-15 transfer is the only way back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            c_reg          <= '0;
            d_reg          <= '0;
            round          <= '0;
            key_ready_q    <= 1'b1;
            subkey_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.key_valid) begin
                        c_reg          <= c_load;
                        d_reg          <= d_load;
                        round          <= '0;
                        key_ready_q    <= 1'b0;
                        subkey_valid_q <= 1'b1;
                        state          <= RUN;
                    end
                end
                RUN: begin
                    if (bus.subkey_ready) begin
                        if (round == 4'd15) begin
                            round          <= '0;
                            key_ready_q    <= 1'b1;
                            subkey_valid_q <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            round <= next_round;
                            c_reg <= c_next;
                            d_reg <= d_next;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // done marks the handshake itself, so it is decoded from the live ready.
    assign bus.done         = subkey_valid_q & bus.subkey_ready & (round == 4'd15);
    assign bus.key_ready    = key_ready_q;
    assign bus.subkey_valid = subkey_valid_q;
    assign bus.subkey_round = round;
    assign bus.subkey       = subkey_w;

endmodule

// File: tb/tb_des_decrypt_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_des_decrypt_key_schedule
// Directed bench for the DES key scheduler. A decrypt-order and an
// encrypt-order instance share the same stimulus.
// ---------------------------------------------------------------------------
module tb_des_decrypt_key_schedule;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    des_decrypt_key_schedule_if dec_bus ();
    des_decrypt_key_schedule_if enc_bus ();

    assign enc_bus.key_in       = dec_bus.key_in;
    assign enc_bus.key_valid    = dec_bus.key_valid;
    assign enc_bus.subkey_ready = dec_bus.subkey_ready;

    des_decrypt_key_schedule #(.ENCRYPT_ORDER(1'b0)) dec_dut (
        .clk (clk),
        .rst (rst),
        .bus (dec_bus)
    );

    des_decrypt_key_schedule #(.ENCRYPT_ORDER(1'b1)) enc_dut (
        .clk (clk),
        .rst (rst),
        .bus (enc_bus)
    );

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [47:0] std_k   [1:16];
    logic [47:0] dec_exp [0:15];
    logic [47:0] enc_exp [0:15];
    logic [63:0] key_k;
    logic [63:0] alt_key;
    bit          check_enc;
    bit          hold_key;

    function automatic logic [63:0] rev64(input logic [63:0] v);
        logic [63:0] r;
        for (int i = 0; i < 64; i++) r[i] = v[63-i];
        return r;
    endfunction

    function automatic logic [47:0] rev48(input logic [47:0] v);
        logic [47:0] r;
        for (int i = 0; i < 48; i++) r[i] = v[47-i];
        return r;
    endfunction

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Offer a key on the next falling edge; it is taken on the rising edge after.
    task automatic applyStimulus(input logic [63:0] k);
        @(negedge clk);
        dec_bus.key_in       = k;
        dec_bus.key_valid    = 1'b1;
        dec_bus.subkey_ready = 1'b1;
        #1;
        checkOutput("key_ready_before_load", {63'b0, dec_bus.key_ready}, 64'd1);
    endtask

    task automatic loadExpectK();
        for (int r = 0; r < 16; r++) begin
            dec_exp[r] = rev48(std_k[16-r]);
            enc_exp[r] = rev48(std_k[r+1]);
        end
    endtask

    task automatic fillExpect(input logic [47:0] v);
        for (int r = 0; r < 16; r++) begin
            dec_exp[r] = v;
            enc_exp[r] = v;
        end
    endtask

    // Walk all 16 rounds with the consumer always ready.
    task automatic checkSchedule(input string tag);
        for (int r = 0; r < 16; r++) begin
            @(negedge clk);
            dec_bus.key_valid    = hold_key;
            if (hold_key) dec_bus.key_in = alt_key;
            dec_bus.subkey_ready = 1'b1;
            #1;
            checkOutput($sformatf("%s_valid_r%0d", tag, r), {63'b0, dec_bus.subkey_valid}, 64'd1);
            checkOutput($sformatf("%s_round_r%0d", tag, r), {60'b0, dec_bus.subkey_round}, 64'(r));
            checkOutput($sformatf("%s_subkey_r%0d", tag, r), {16'b0, dec_bus.subkey}, {16'b0, dec_exp[r]});
            checkOutput($sformatf("%s_kready_r%0d", tag, r), {63'b0, dec_bus.key_ready}, 64'd0);
            checkOutput($sformatf("%s_done_r%0d", tag, r), {63'b0, dec_bus.done}, (r == 15) ? 64'd1 : 64'd0);
            if (check_enc)
                checkOutput($sformatf("%s_enc_subkey_r%0d", tag, r), {16'b0, enc_bus.subkey}, {16'b0, enc_exp[r]});
        end
        @(negedge clk);
        #1;
        checkOutput($sformatf("%s_kready_after", tag), {63'b0, dec_bus.key_ready}, 64'd1);
        checkOutput($sformatf("%s_valid_after", tag), {63'b0, dec_bus.subkey_valid}, 64'd0);
    endtask

    initial begin
        int  idx;
        int  cycles;
        int  done_cnt;
        bit  rdy;

        rst                  = 1'b1;
        dec_bus.key_in       = '0;
        dec_bus.key_valid    = 1'b0;
        dec_bus.subkey_ready = 1'b0;
        check_enc            = 1'b1;
        hold_key             = 1'b0;
        alt_key              = '0;

        std_k = '{48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
                  48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
                  48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
                  48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5};
        key_k = rev64(64'h133457799BBCDFF1);
        loadExpectK();

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_key_ready", {63'b0, dec_bus.key_ready}, 64'd1);
        checkOutput("rst_subkey_valid", {63'b0, dec_bus.subkey_valid}, 64'd0);
        checkOutput("rst_done", {63'b0, dec_bus.done}, 64'd0);
        checkOutput("rst_round", {60'b0, dec_bus.subkey_round}, 64'd0);
        checkOutput("rst_subkey", {16'b0, dec_bus.subkey}, 64'd0);
        checkOutput("rst_enc_key_ready", {63'b0, enc_bus.key_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0;

        // Full schedule, both orders, no stalls
        applyStimulus(key_k);
        checkSchedule("nostall");

        // Random stalls on the consumer side
        $display("[TB] random subkey_ready stalls");
        applyStimulus(key_k);
        idx = 0; cycles = 0; done_cnt = 0;
        while (idx < 16 && cycles < 400) begin
            @(negedge clk);
            dec_bus.key_valid    = 1'b0;
            rdy                  = 1'($urandom_range(0, 1));
            dec_bus.subkey_ready = rdy;
            #1;
            checkOutput($sformatf("stall_valid_%0d", cycles), {63'b0, dec_bus.subkey_valid}, 64'd1);
            checkOutput($sformatf("stall_round_%0d", cycles), {60'b0, dec_bus.subkey_round}, 64'(idx));
            checkOutput($sformatf("stall_subkey_%0d", cycles), {16'b0, dec_bus.subkey}, {16'b0, dec_exp[idx]});
            checkOutput($sformatf("stall_done_%0d", cycles), {63'b0, dec_bus.done},
                        (rdy && idx == 15) ? 64'd1 : 64'd0);
            if (dec_bus.done) done_cnt++;
            if (rdy) idx++;
            cycles++;
        end
        if (idx < 16) checkOutput("stall_timeout", 64'(idx), 64'd16);
        checkOutput("stall_done_count", 64'(done_cnt), 64'd1);
        dec_bus.subkey_ready = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("stall_kready_after", {63'b0, dec_bus.key_ready}, 64'd1);

        // key_valid held through RUN with a second (all-zero) key
        hold_key = 1'b1;
        alt_key  = 64'h0;
        applyStimulus(key_k);
        checkSchedule("hold_first");
        hold_key = 1'b0;
        fillExpect(48'h0);
        checkSchedule("zero_key");

        // All-ones weak key
        fillExpect(48'hFFFFFFFFFFFF);
        applyStimulus(64'hFFFFFFFFFFFFFFFF);
        checkSchedule("ones_key");

        // Reset at round 7, then reload
        loadExpectK();
        applyStimulus(key_k);
        for (int r = 0; r < 7; r++) begin
            @(negedge clk);
            dec_bus.key_valid    = 1'b0;
            dec_bus.subkey_ready = 1'b1;
        end
        @(negedge clk);
        #1;
        checkOutput("mid_round7", {60'b0, dec_bus.subkey_round}, 64'd7);
        checkOutput("mid_subkey7", {16'b0, dec_bus.subkey}, {16'b0, dec_exp[7]});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_key_ready", {63'b0, dec_bus.key_ready}, 64'd1);
        checkOutput("mid_rst_valid", {63'b0, dec_bus.subkey_valid}, 64'd0);
        checkOutput("mid_rst_done", {63'b0, dec_bus.done}, 64'd0);
        applyStimulus(key_k);
        checkSchedule("after_rst");

        // Reset and key_valid together: reset wins
        @(negedge clk);
        rst               = 1'b1;
        dec_bus.key_in    = key_k;
        dec_bus.key_valid = 1'b1;
        @(negedge clk);
        rst               = 1'b0;
        dec_bus.key_valid = 1'b0;
        #1;
        checkOutput("rst_vs_key_ready", {63'b0, dec_bus.key_ready}, 64'd1);
        checkOutput("rst_vs_key_valid", {63'b0, dec_bus.subkey_valid}, 64'd0);
        @(negedge clk);
        #1;
        checkOutput("rst_vs_key_idle", {63'b0, dec_bus.subkey_valid}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/des_decrypt_key_schedule.md
# des_decrypt_key_schedule

Sequential DES key scheduler that emits the sixteen 48-bit round subkeys in decryption order, K16 first and K1 last. It is the reverse-direction counterpart of the encryption key path. It accepts a 64-bit key over a valid/ready handshake and streams one subkey per accepted beat to the Feistel round datapath. Bit numbering follows the codebase convention: vector bit i holds DES bit i+1.

## Interface
- `ENCRYPT_ORDER`, default 0: when 1, emits K1..K16 using left rotations. Default is decryption order.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `key_in` in 64: DES key, `key_in[0]` = DES bit 1. Parity bits are ignored.
- `key_valid` in 1: key offered.
- `key_ready` out 1: scheduler idle and able to accept a key.
- `subkey` out 48: current round subkey, `subkey[0]` = DES subkey bit 1.
- `subkey_round` out 4: index of the consuming round, 0..15. Round r carries K(16−r) in decrypt order.
- `subkey_valid` out 1: `subkey` is valid.
- `subkey_ready` in 1: consumer accepts the subkey.
- `done` out 1: one-cycle pulse on the accepted transfer of round 15.

## Operation
- States: IDLE, RUN.
- IDLE:
  - `key_ready`=1.
  - On `key_valid & key_ready`, load C = PC1(`key_in`)[27:0] and D = PC1(`key_in`)[55:28], clear the round counter, and go to RUN.
- RUN:
  - `subkey` = PC2({D,C}) is combinational from the C/D registers, and `subkey_valid`=1.
  - On `subkey_valid & subkey_ready` with round < 15: increment the round counter and rotate C and D by the shift for the next round.
  - On the same handshake at round 15: pulse `done` and return to IDLE.
- Decrypt shift sequence, applied when moving into rounds 1..15: 1,2,2,2,2,2,2,1,2,2,2,2,2,2,1. Round 0 uses no shift, because after 28 total shifts C0/D0 equals C16/D16.
- Decrypt rotation is a DES right rotate. In vector terms:
  - by 1: {C[26:0],C[27]}
  - by 2: {C[25:0],C[27:26]}
  - D is rotated the same way.
- `ENCRYPT_ORDER`=1:
  - The load applies a left rotate by 1: {C[0],C[27:1]}.
  - Subsequent shifts follow 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1, indexed from round 1.
- Backpressure: while `subkey_valid & ~subkey_ready`, all state holds and `subkey`/`subkey_round` stay stable.
- `key_valid` while in RUN is ignored; `key_ready`=0 throughout RUN.

## Timing
- Reset values:
  - state = IDLE
  - `key_ready`=1
  - `subkey_valid`=0
  - `done`=0
  - `subkey_round`=0
  - `subkey`=PC2(0)=0
- Latency: key accepted at edge N, so `subkey_valid`=1 with round 0 from cycle N+1.
- With `subkey_ready` tied high, 16 subkeys appear on 16 consecutive cycles and `done` is high in the cycle of round 15.
  - `key_ready` returns in the cycle after the round-15 handshake.
  - Back-to-back keys therefore cost 17 cycles per key.
- `rst` asserted mid-RUN forces IDLE on the next edge, discarding the schedule. No `done` is produced.
- `rst` and `key_valid` in the same cycle: reset wins and the key is not loaded.
- The round counter never wraps. Exiting at 15 is the only path out of RUN.

## Structure
- Shared package `des_pkg`:
  - PC1 index constant array (56 entries, zero-based, codebase bit order).
  - Decrypt and encrypt shift-amount arrays (16 × 2-bit).
  - State enum {IDLE, RUN}.
- New sub-module `Permuted_Choice_1`: combinational 64→56 permutation.
- Reuse the existing `Permuted_Choice_2` for 56→48 compression, instanced once on {D,C}.
- The top level holds the FSM, round counter, C/D registers and rotate muxes.

## Test plan
In this plan, key K = bit-reverse of 64'h133457799BBCDFF1.
- K loaded with `subkey_ready`=1 → round 0 `subkey` = bit-reverse of 48'hCB3D8B0E17F5 (K16); round 15 = bit-reverse of 48'h1B02EFFC7072 (K1). `done` pulses at round 15.
- Same key with `ENCRYPT_ORDER`=1 → round 0 = K1 value, round 15 = K16 value. Full sequence matches the golden-model schedule.
- Random `subkey_ready` stalls (≈50%) → the sequence is identical to the no-stall run and `subkey` is stable while stalled. `done` occurs exactly once.
- `key_valid` held high during RUN with a different key → ignored. Sixteen subkeys of the first key are emitted, then the second key is accepted once `key_ready`=1.
- `rst` pulsed at round 7 → next cycle `key_ready`=1, `subkey_valid`=0, no `done`. A reload then yields the correct K16 at round 0.
- Key 64'h0 and 64'hFFFFFFFFFFFFFFFF (all ones) → all sixteen subkeys are 48'h0 and 48'hFFFFFFFFFFFF (all ones) respectively (weak-key check).
